// File: rtl/rings_vga_gen.sv
// rings_vga_gen: VGA timing generator with animated concentric-ring pixels.
// Counters feed a 3-stage pixel pipeline; syncs travel alongside the pixels so
// hsync/vsync/display_on/rgb stay aligned. Phase advances once per frame.
// Optional build macro RINGS_DITHER_EN enables a 2x2 ordered dither on the
// palette output (channel value 1 becomes 2 on odd checkerboard pixels).
module rings_vga_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int NUM_RINGS  = 4,
  parameter int RING_SHIFT = 4,
  parameter int PHASE_W    = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] speed,
  input  logic       pause,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int KW       = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FRAME  = VW'(VS_START);
  localparam logic [10:0]   H_CENTRE = 11'(H_ACTIVE / 2);
  localparam logic [10:0]   V_CENTRE = 11'(V_ACTIVE / 2);

  logic [HW-1:0]      hcnt;
  logic [VW-1:0]      vcnt;
  logic [PHASE_W-1:0] phase;

  // stage 1: syncs, visibility and centre distances per axis
  logic        s1_hs, s1_vs, s1_vis;
  logic [10:0] s1_dx, s1_dy;
  // stage 2: combined ring distance
  logic        s2_hs, s2_vs, s2_vis;
  logic [10:0] s2_dist;
`ifdef RINGS_DITHER_EN
  logic        s1_dith, s2_dith;
`endif

  // stage-0 combinational terms taken straight from the counters
  logic        c_hs, c_vs, c_vis;
  logic [10:0] c_hx, c_vy, c_dx, c_dy;
  logic [10:0] c_max, c_min;
  logic [11:0] c_sum;
  logic [10:0] c_dist;
  logic [PHASE_W-1:0] c_ring_pos;
  logic [KW-1:0]      c_k;
  logic [5:0]         c_kp1, c_c6;
  logic [1:0]         c_r, c_g, c_b;

  // Sync windows, centre distances, distance metric and palette lookup
  always_comb begin
    c_hs  = !(int'(hcnt) >= HS_START && int'(hcnt) < HS_END);
    c_vs  = !(int'(vcnt) >= VS_START && int'(vcnt) < VS_END);
    c_vis = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
    c_hx  = 11'(hcnt);
    c_vy  = 11'(vcnt);
    c_dx  = (c_hx >= H_CENTRE) ? (c_hx - H_CENTRE) : (H_CENTRE - c_hx);
    c_dy  = (c_vy >= V_CENTRE) ? (c_vy - V_CENTRE) : (V_CENTRE - c_vy);

    c_max  = (s1_dx >= s1_dy) ? s1_dx : s1_dy;
    c_min  = (s1_dx >= s1_dy) ? s1_dy : s1_dx;
    c_sum  = {1'b0, c_max} + 12'(c_min >> 1);
    c_dist = c_sum[11] ? '1 : c_sum[10:0];

    c_ring_pos = PHASE_W'(s2_dist) + phase;
    c_k        = KW'(c_ring_pos >> RING_SHIFT);
    // (k+1)*21 mod 64 computed entirely in 6-bit arithmetic
    c_kp1      = 6'(c_k) + 6'd1;
    c_c6       = c_kp1 * 6'd21;
    c_r        = c_c6[5:4];
    c_g        = c_c6[3:2];
    c_b        = c_c6[1:0];
`ifdef RINGS_DITHER_EN
    if (s2_dith && c_r == 2'd1) c_r = 2'd2;
    if (s2_dith && c_g == 2'd1) c_g = 2'd2;
    if (s2_dith && c_b == 2'd1) c_b = 2'd2;
`endif
  end

  // Pixel counters, frame counter and per-frame phase accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      phase     <= '0;
      frame_cnt <= '0;
    end else if (ena) begin
      if (hcnt == '0 && vcnt == V_FRAME) begin
        frame_cnt <= frame_cnt + 8'd1;
        if (!pause) phase <= phase + PHASE_W'(speed);
      end
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Three-stage pixel pipeline; syncs ride along so every output shares latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
      s1_vis     <= 1'b0;
      s1_dx      <= '0;
      s1_dy      <= '0;
      s2_hs      <= 1'b1;
      s2_vs      <= 1'b1;
      s2_vis     <= 1'b0;
      s2_dist    <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      display_on <= 1'b0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
`ifdef RINGS_DITHER_EN
      s1_dith    <= 1'b0;
      s2_dith    <= 1'b0;
`endif
    end else if (ena) begin
      s1_hs      <= c_hs;
      s1_vs      <= c_vs;
      s1_vis     <= c_vis;
      s1_dx      <= c_dx;
      s1_dy      <= c_dy;
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      s2_vis     <= s1_vis;
      s2_dist    <= c_dist;
      hsync      <= s2_hs;
      vsync      <= s2_vs;
      display_on <= s2_vis;
      r          <= s2_vis ? c_r : 2'd0;
      g          <= s2_vis ? c_g : 2'd0;
      b          <= s2_vis ? c_b : 2'd0;
`ifdef RINGS_DITHER_EN
      s1_dith    <= hcnt[0] ^ vcnt[0];
      s2_dith    <= s1_dith;
`endif
    end
  end

endmodule

// File: tb/tb_rings_vga_gen.sv
// Directed bench for rings_vga_gen using a reduced 48x24 timing so many
// frames fit in a short run. Centre is (20,10); hsync low for hcnt 42..45,
// vsync low for vcnt 21..22, frame event at (0,21).
module tb_rings_vga_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [2:0] speed = 3'd0;
  logic       pause = 1'b0;
  logic       hsync, vsync, display_on;
  logic [1:0] r, g, b;
  logic [7:0] frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // reference counters, independent of the DUT
  logic [5:0] mh;
  logic [4:0] mv;
  logic [7:0] mframe;

  rings_vga_gen #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(20), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .NUM_RINGS(4), .RING_SHIFT(4), .PHASE_W(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .speed(speed), .pause(pause),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .r(r), .g(g), .b(b), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // reference raster position and frame count
  always @(posedge clk) begin
    if (!rst_n) begin
      mh <= '0; mv <= '0; mframe <= '0;
    end else if (ena) begin
      if (mh == 6'd0 && mv == 5'd21) mframe <= mframe + 8'd1;
      if (mh == 6'd47) begin
        mh <= '0;
        mv <= (mv == 5'd23) ? 5'd0 : mv + 5'd1;
      end else begin
        mh <= mh + 6'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stop when the counter sits on (x,y), then advance to where that pixel is output
  task automatic wait_pix(input int x, input int y);
    bit found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk); #1;
      if (int'(mh) == x && int'(mv) == y) found = 1;
    end
    chk($sformatf("reach_%0d_%0d", x, y), 32'(found), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n);
    logic [7:0] target = mframe + 8'(n);
    bit found = 0;
    for (int i = 0; i < n * 1152 + 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (mframe == target) found = 1;
    end
    chk("frame_wait", 32'(found), 32'd1);
  endtask

  function automatic logic [31:0] rgb();
    return 32'({r, g, b});
  endfunction

  initial begin
    int hs_low, vs_low, de_cnt, frozen_bad;

    // reset held 4 clocks
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_de", 32'(display_on), 32'd0);
    chk("rst_rgb", rgb(), 32'h00);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;

    // static picture at phase 0
    wait_pix(42, 5);
    chk("hsync_low", 32'(hsync), 32'd0);
    chk("vsync_high", 32'(vsync), 32'd1);
    wait_pix(20, 10);
    chk("centre_de", 32'(display_on), 32'd1);
    chk("centre_rgb", rgb(), 32'h15);
    wait_pix(36, 10);
    chk("dist16_rgb", rgb(), 32'h2A);
    wait_pix(45, 10);
    chk("blank_de", 32'(display_on), 32'd0);
    chk("blank_rgb", rgb(), 32'h00);
    wait_pix(0, 21);
    chk("vsync_low", 32'(vsync), 32'd0);
    wait_pix(0, 0);
    chk("corner_rgb", rgb(), 32'h2A);
    wait_pix(21, 10);
`ifdef RINGS_DITHER_EN
    chk("dither_rgb", rgb(), 32'h2A);
`else
    chk("dither_rgb", rgb(), 32'h15);
`endif
    wait_pix(20, 10);
    chk("centre_nodither", rgb(), 32'h15);

    // two full frames of sync/visible counts
    wait_pix(0, 0);
    hs_low = 0; vs_low = 0; de_cnt = 0;
    for (int i = 0; i < 2 * 1152; i++) begin
      @(posedge clk); #1;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (display_on) de_cnt++;
    end
    chk("hsync_count", 32'(hs_low), 32'd192);
    chk("vsync_count", 32'(vs_low), 32'd192);
    chk("visible_count", 32'(de_cnt), 32'd1600);
    chk("frame_cnt_a", 32'(frame_cnt), 32'(mframe));

    // animation: 16 frames at speed 1 -> phase 16
    speed = 3'd1;
    wait_frames(16);
    speed = 3'd0;
    chk("frame_cnt_anim", 32'(frame_cnt), 32'(mframe));
    wait_pix(20, 10);
    chk("anim_centre", rgb(), 32'h2A);
    wait_pix(36, 10);
    chk("anim_dist16", rgb(), 32'h3F);

    // paused for 3 frames at speed 7: phase stays 16
    pause = 1'b1;
    speed = 3'd7;
    wait_frames(3);
    wait_pix(20, 10);
    chk("paused_centre", rgb(), 32'h2A);
    // unpaused for 3 frames: phase 37
    pause = 1'b0;
    wait_frames(3);
    speed = 3'd0;
    wait_pix(20, 10);
    chk("resume_centre", rgb(), 32'h3F);

    // ena low for 100 clocks: outputs hold the (20,10) pixel
    ena = 1'b0;
    frozen_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (hsync !== 1'b1 || vsync !== 1'b1 || display_on !== 1'b1 ||
          {r, g, b} !== 6'h3F) frozen_bad++;
    end
    chk("ena_frozen", 32'(frozen_bad), 32'd0);
    chk("ena_frame_hold", 32'(frame_cnt), 32'(mframe));
    ena = 1'b1;
    // phase 37 + dist 16 = 53 -> ring 3 -> (1,1,0)
    wait_pix(36, 10);
    chk("ena_resume_rgb", rgb(), 32'h14);
    chk("ena_resume_frame", 32'(frame_cnt), 32'(mframe));

    // mid-frame reset restarts everything
    wait_pix(10, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_frame", 32'(frame_cnt), 32'd0);
    chk("midrst_de", 32'(display_on), 32'd0);
    wait_pix(20, 10);
    chk("midrst_centre", rgb(), 32'h15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
